// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
// Read-side consumer of asynchronous_fifo in the rdclk domain. Issues rd_en,
// captures the registered data_out one cycle later into a 2-entry skid buffer
// and presents the words as a full-throughput valid/ready stream.
// Optional statistics counters (word_cnt, stall_cnt) are built only when the
// macro RD_STATS_EN is defined.
`timescale 1ns/1ps

module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  rdclk,
  input  logic                  rrst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef RD_STATS_EN
  ,
  output logic [31:0]           word_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  // The buffer indexing below only covers two entries.
  if (SKID_DEPTH != 2) begin : g_bad_depth
    $error("fifo_rd_stream_adapter: SKID_DEPTH must be 2");
  end

  logic [1:0]            occ;       // buffered words, 0..2
  logic [1:0]            occ_next;
  logic                  inflight;  // rd_en was issued last cycle
  logic                  drop;      // in-flight word must be discarded
  logic [DATA_WIDTH-1:0] buf0;      // head entry
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop;
  logic                  capture;
  logic                  tail;      // capture slot: 0 -> buf0, 1 -> buf1
  logic [2:0]            level;     // occupancy after this edge, counting the read in flight

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf0;

  // Read issue, capture and occupancy bookkeeping for this cycle.
  // NOTE: every always_comb output gets a value before any condition, so no latch can be inferred.
  always_comb begin
    pop      = m_valid & m_ready;
    level    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    // m_ready feeds rd_en combinationally so a popping buffer can refill every cycle.
    rd_en    = rrst_n & ~flush & ~fifo_empty & (level < 3'd2);
    capture  = inflight & ~drop;
    occ_next = occ + {1'b0, capture} - {1'b0, pop};
    // Tail slot is occ - pop; it is only ever 0 or 1 when a capture happens.
    tail     = (occ == 2'd2) | ((occ == 2'd1) & ~pop);
  end

  // Skid buffer state: occupancy, in-flight tracking and entry storage.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the two data entries are reset because m_data must read 0 out of reset.
  always_ff @(posedge rdclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else if (flush) begin
      // Buffered words vanish, a pop in this cycle is void and rd_en is low.
      occ      <= 2'd0;
      drop     <= inflight;
      inflight <= rd_en;
    end else begin
      occ      <= occ_next;
      inflight <= rd_en;
      drop     <= 1'b0;
      if (pop && (occ == 2'd2)) begin
        buf0 <= buf1;
      end
      if (capture) begin
        if (tail) buf1 <= data_out;
        else      buf0 <= data_out;
      end
    end
  end

`ifdef RD_STATS_EN
  // Transfer counter (wraps) and stall counter (saturates); both clear on flush.
  always_ff @(posedge rdclk or negedge rrst_n) begin
    if (!rrst_n) begin
      word_cnt  <= 32'd0;
      stall_cnt <= 16'd0;
    end else if (flush) begin
      word_cnt  <= 32'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (pop) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

  // Occupancy can never pass the two physical entries.
  occ_bound: assert property (@(posedge rdclk) disable iff (!rrst_n) occ <= 2'd2)
    else $error("fifo_rd_stream_adapter: occupancy overflow");

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter
// Self-checking bench: a behavioural FIFO with one-cycle registered read
// feeds the adapter; words read out of the FIFO are queued as expected
// stream output and compared in order as the stream pops them.
`timescale 1ns/1ps

module tb_fifo_rd_stream_adapter;

  localparam int DW = 8;

  logic          rdclk;
  logic          rrst_n;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] data_out;
  logic          rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef RD_STATS_EN
  logic [31:0]   word_cnt;
  logic [15:0]   stall_cnt;
`endif

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .SKID_DEPTH(2)) dut (
    .rdclk      (rdclk),
    .rrst_n     (rrst_n),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .data_out   (data_out),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef RD_STATS_EN
    ,
    .word_cnt   (word_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_q[$];   // words waiting in the FIFO model
  logic [DW-1:0] pend_q[$];   // scoreboard: words read from the FIFO, not yet delivered

  // Values sampled in the most recent tick (before its clock edge).
  logic          obs_rd;
  logic          obs_valid;
  logic [DW-1:0] obs_data;
  int            rd_total;

  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          first_seen;
  logic [DW-1:0] first_word;
  logic [31:0]   exp_words;
  logic [15:0]   exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample mid-cycle, score pops, then model the FIFO after the edge.
  task automatic tick();
    logic rd_s, pop_s, fl_s, stall_s;
    logic [DW-1:0] w;
    #1;
    rd_s      = rd_en;
    fl_s      = flush;
    pop_s     = m_valid & m_ready & rrst_n;
    stall_s   = m_valid & ~m_ready & rrst_n;
    obs_rd    = rd_en;
    obs_valid = m_valid;
    obs_data  = m_data;
    if (rd_s) rd_total++;

    if (prev_stall && rrst_n) begin
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
    end
    prev_stall = stall_s & ~fl_s;
    prev_data  = m_data;

    if (pop_s && !fl_s) begin
      check("pop_expected", {31'd0, pend_q.size() != 0}, 32'd1);
      if (pend_q.size() != 0) begin
        w = pend_q.pop_front();
        check("stream_data", {24'd0, m_data}, {24'd0, w});
        if (!first_seen) begin
          first_seen = 1'b1;
          first_word = m_data;
        end
      end
    end

`ifdef RD_STATS_EN
    check("word_cnt", word_cnt, exp_words);
    check("stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_stall});
`endif

    @(posedge rdclk);
    #1;
    if (fl_s) pend_q.delete();
    if (rd_s) begin
      check("rd_on_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
      if (fifo_q.size() != 0) begin
        data_out = fifo_q.pop_front();
        pend_q.push_back(data_out);
      end
    end
    fifo_empty = (fifo_q.size() == 0);

    if (!rrst_n || fl_s) begin
      exp_words = 32'd0;
      exp_stall = 16'd0;
    end else begin
      if (pop_s) exp_words = exp_words + 32'd1;
      if (stall_s && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    m_ready = 1'b1;
    while ((fifo_q.size() != 0 || pend_q.size() != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", {31'd0, (fifo_q.size() == 0) && (pend_q.size() == 0) && !m_valid}, 32'd1);
  endtask

  initial begin
    rrst_n = 1'b0; flush = 1'b0; fifo_empty = 1'b1; data_out = '0; m_ready = 1'b0;
    rd_total = 0; prev_stall = 1'b0; prev_data = '0; first_seen = 1'b0; first_word = '0;
    exp_words = 32'd0; exp_stall = 16'd0; obs_rd = 1'b0; obs_valid = 1'b0; obs_data = '0;

    // Reset state
    #3;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    @(posedge rdclk); @(posedge rdclk); #1;
    rrst_n = 1'b1;

    // Empty FIFO: nothing issued, nothing presented
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("empty_rd_en", {31'd0, obs_rd}, 32'd0);
      check("empty_valid", {31'd0, obs_valid}, 32'd0);
    end

    // Three words at full rate: latency and back-to-back delivery
    rd_total = 0;
    load(8'h11); load(8'h22); load(8'h33);
    tick(); check("lat_rd_n", {31'd0, obs_rd}, 32'd1); check("lat_valid_n", {31'd0, obs_valid}, 32'd0);
    tick(); check("lat_valid_n1", {31'd0, obs_valid}, 32'd0);
    tick(); check("lat_valid_n2", {31'd0, obs_valid}, 32'd1); check("word0", {24'd0, obs_data}, 32'h11);
    tick(); check("word1", {24'd0, obs_data}, 32'h22);
    tick(); check("word2", {24'd0, obs_data}, 32'h33);
    tick(); check("after_valid", {31'd0, obs_valid}, 32'd0);
    check("rd_cycles3", rd_total, 32'd3);
    drain(20);

    // Five words with the sink stalled: buffer fills to two, nothing lost
    m_ready = 1'b0;
    rd_total = 0;
    for (int i = 1; i <= 5; i++) load(DW'(i));
    for (int i = 0; i < 6; i++) tick();
    check("stall_rd_issues", rd_total, 32'd2);
    check("stall_fifo_left", fifo_q.size(), 32'd3);
    check("stall_valid", {31'd0, obs_valid}, 32'd1);
    check("stall_head", {24'd0, obs_data}, 32'h01);
    drain(40);

    // Toggling ready: order kept, data held while stalled
    load(8'hB1); load(8'hB2); load(8'hB3); load(8'hB4);
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    drain(40);

    // Flush with a word in flight and one buffered
    m_ready = 1'b0;
    load(8'hC1);
    tick(); tick(); tick();
    check("pre_flush_valid", {31'd0, m_valid}, 32'd1);
    load(8'hC2); load(8'hA5);
    tick(); check("pre_flush_rd", {31'd0, obs_rd}, 32'd1);
    flush = 1'b1;
    tick(); check("flush_rd_low", {31'd0, obs_rd}, 32'd0);
    flush = 1'b0;
    tick(); check("post_flush_valid", {31'd0, obs_valid}, 32'd0);
    first_seen = 1'b0;
    drain(40);
    check("first_after_flush", {24'd0, first_word}, 32'hA5);

`ifdef RD_STATS_EN
    // Stall counter saturation
    m_ready = 1'b0;
    load(8'hD1);
    for (int i = 0; i < 65545; i++) tick();
    check("stall_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
    drain(20);
`endif

    // Reset pulled mid-stream
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) load(DW'(8'hE0 + i));
    tick(); tick(); tick(); tick();
    rrst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_rd_en", {31'd0, rd_en}, 32'd0);
    check("midrst_data", {24'd0, m_data}, 32'd0);
`ifdef RD_STATS_EN
    check("midrst_word_cnt", word_cnt, 32'd0);
`endif
    fifo_q.delete(); pend_q.delete();
    fifo_empty = 1'b1; data_out = '0; prev_stall = 1'b0;
    exp_words = 32'd0; exp_stall = 16'd0;
    tick();
    rrst_n = 1'b1;
    load(8'hF1); load(8'hF2);
    first_seen = 1'b0;
    drain(20);
    check("first_after_reset", {24'd0, first_word}, 32'hF1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
